// File: rtl/irq_controller_n_pkg.sv
// Shared definitions for the interrupt controller: handshake states, source indices,
// default bus addresses and vector constants.
package irq_controller_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } irq_state_e;

    localparam int SRC_VBLANK = 0;
    localparam int SRC_LCDC   = 1;
    localparam int SRC_TIMER  = 2;
    localparam int SRC_SERIAL = 3;
    localparam int SRC_INPUT  = 4;

    localparam logic [15:0] DEF_IF_ADDR       = 16'hFF0F;
    localparam logic [15:0] DEF_IE_ADDR       = 16'hFFFF;
    localparam logic [7:0]  DEF_VECTOR_BASE   = 8'h40;
    localparam logic [7:0]  DEF_VECTOR_STRIDE = 8'h08;

    // A single source still needs a 1-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_controller_n_prio_enc.sv
// Lowest-index-first priority encoder: index 0 wins.
module irq_prio_enc #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_vec,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        o_valid = |i_vec;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = IW'(i);
        end
    end

endmodule

// File: rtl/irq_controller_n.sv
// Interrupt controller: edge-latched IF, IE mask, int_n / m1_n+iorq_n acknowledge
// handshake and a computed jump vector for the selected source.
import irq_controller_n_pkg::*;

module irq_controller_n #(
    parameter int          NUM_INT       = 5,
    parameter logic [7:0]  VECTOR_BASE   = DEF_VECTOR_BASE,
    parameter logic [7:0]  VECTOR_STRIDE = DEF_VECTOR_STRIDE,
    parameter logic [15:0] IF_ADDR       = DEF_IF_ADDR,
    parameter logic [15:0] IE_ADDR       = DEF_IE_ADDR
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               m1_n,
    input  logic               iorq_n,
    output logic               int_n,
    input  logic [NUM_INT-1:0] int_req,
    output logic [NUM_INT-1:0] int_ack,
    output logic [7:0]         jump_addr,
    input  logic [15:0]        A,
    input  logic [7:0]         Di,
    output logic [7:0]         Do,
    input  logic               wr_n,
    input  logic               rd_n,
    input  logic               cs
);

    localparam int SW = sel_width(NUM_INT);

    logic [NUM_INT-1:0] r_req_q, r_if, r_ie;
    logic [NUM_INT-1:0] w_rise, w_pending, w_if_nxt;
    logic [SW-1:0]      r_sel, w_enc_idx;
    logic               w_enc_valid;
    logic               w_wr_if, w_wr_ie, w_rd, w_cpu_ack;
    irq_state_e         r_state, w_state_nxt;

    assign w_rise    = int_req & ~r_req_q;
    assign w_pending = r_if & r_ie;
    assign w_wr_if   = cs & ~wr_n & (A == IF_ADDR);
    assign w_wr_ie   = cs & ~wr_n & (A == IE_ADDR);
    assign w_rd      = cs & ~rd_n & wr_n;
    assign w_cpu_ack = ~m1_n & ~iorq_n;

    irq_prio_enc #(.N(NUM_INT), .IW(SW)) u_enc (
        .i_vec   (w_pending),
        .o_valid (w_enc_valid),
        .o_idx   (w_enc_idx)
    );

    // A fresh rising edge always wins over a software write or the ack-clear.
    always_comb begin
        w_if_nxt = r_if;
        if (w_wr_if) w_if_nxt = Di[NUM_INT-1:0];
        if (r_state == ST_ACK) w_if_nxt[r_sel] = 1'b0;
        w_if_nxt = w_if_nxt | w_rise;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_req_q <= '0;
            r_if    <= '0;
            r_ie    <= '0;
            r_sel   <= '0;
        end else begin
            r_req_q <= int_req;
            r_if    <= w_if_nxt;
            if (w_wr_ie) r_ie <= Di[NUM_INT-1:0];
            if (r_state == ST_IDLE && w_enc_valid) r_sel <= w_enc_idx;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // sel is frozen once the request is raised; only withdrawal or ack leaves REQ.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_enc_valid) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (!w_pending[r_sel]) w_state_nxt = ST_IDLE;
                else if (w_cpu_ack)    w_state_nxt = ST_ACK;
            end
            ST_ACK:  w_state_nxt = ST_DONE;
            ST_DONE: if (!w_cpu_ack) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        int_n   = (r_state != ST_REQ);
        int_ack = '0;
        if (r_state == ST_ACK) int_ack[r_sel] = 1'b1;
    end

    assign jump_addr = VECTOR_BASE + 8'(r_sel) * VECTOR_STRIDE;

    // Unimplemented upper bits read back as ones.
    always_comb begin
        Do = 8'hFF;
        if (w_rd && A == IF_ADDR)      Do[NUM_INT-1:0] = r_if;
        else if (w_rd && A == IE_ADDR) Do[NUM_INT-1:0] = r_ie;
    end

endmodule

// File: tb/tb_irq_controller_n.sv
// Bench for irq_controller_n: directed handshake scenarios plus random traffic checked
// every cycle against a behavioural model; a second 8-source instance checks vector wrap.
module tb_irq_controller_n;

    localparam int          NI  = 5;
    localparam logic [15:0] IFA = 16'hFF0F;
    localparam logic [15:0] IEA = 16'hFFFF;
    localparam int P_IDLE = 0, P_REQ = 1, P_ACK = 2, P_DONE = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic          m1_n = 1'b1, iorq_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, cs = 1'b0;
    logic [NI-1:0] int_req = '0;
    logic [15:0]   A = '0;
    logic [7:0]    Di = '0;
    logic          int_n;
    logic [NI-1:0] int_ack;
    logic [7:0]    jump_addr, Do;

    logic          m1_8 = 1'b1, iorq_8 = 1'b1, wr8 = 1'b1, rd8 = 1'b1, cs8 = 1'b0;
    logic [7:0]    req8 = '0;
    logic [15:0]   A8 = '0;
    logic [7:0]    Di8 = '0;
    logic          int_n8;
    logic [7:0]    ack8, jump8, do8;

    irq_controller_n dut (
        .clock(clock), .reset_n(reset_n), .m1_n(m1_n), .iorq_n(iorq_n), .int_n(int_n),
        .int_req(int_req), .int_ack(int_ack), .jump_addr(jump_addr), .A(A), .Di(Di),
        .Do(Do), .wr_n(wr_n), .rd_n(rd_n), .cs(cs)
    );

    irq_controller_n #(.NUM_INT(8), .VECTOR_BASE(8'hF0)) dut8 (
        .clock(clock), .reset_n(reset_n), .m1_n(m1_8), .iorq_n(iorq_8), .int_n(int_n8),
        .int_req(req8), .int_ack(ack8), .jump_addr(jump8), .A(A8), .Di(Di8),
        .Do(do8), .wr_n(wr8), .rd_n(rd8), .cs(cs8)
    );

    int n_cmp = 0, n_err = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NI-1:0] m_if, m_ie, m_reqq;
    int            m_phase, m_sel;

    function automatic int lowest(input logic [NI-1:0] v);
        for (int i = 0; i < NI; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [NI-1:0] f_next_if();
        logic [NI-1:0] n;
        n = m_if;
        if (cs && !wr_n && A == IFA) n = Di[NI-1:0];
        if (m_phase == P_ACK) n[m_sel] = 1'b0;
        return n | (int_req & ~m_reqq);
    endfunction

    function automatic int f_next_phase();
        logic [NI-1:0] pend;
        pend = m_if & m_ie;
        case (m_phase)
            P_IDLE:  return (pend != 0) ? P_REQ : P_IDLE;
            P_REQ:   return !pend[m_sel] ? P_IDLE : ((!m1_n && !iorq_n) ? P_ACK : P_REQ);
            P_ACK:   return P_DONE;
            default: return (m1_n || iorq_n) ? P_IDLE : P_DONE;
        endcase
    endfunction

    function automatic int f_next_sel();
        logic [NI-1:0] pend;
        pend = m_if & m_ie;
        return (m_phase == P_IDLE && pend != 0) ? lowest(pend) : m_sel;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_if <= '0; m_ie <= '0; m_reqq <= '0; m_phase <= P_IDLE; m_sel <= 0;
        end else begin
            m_if    <= f_next_if();
            m_ie    <= (cs && !wr_n && A == IEA) ? Di[NI-1:0] : m_ie;
            m_reqq  <= int_req;
            m_phase <= f_next_phase();
            m_sel   <= f_next_sel();
        end
    end

    function automatic logic [7:0] e_do();
        logic [7:0] r;
        r = 8'hFF;
        if (cs && !rd_n && wr_n) begin
            if (A == IFA)      r[NI-1:0] = m_if;
            else if (A == IEA) r[NI-1:0] = m_ie;
        end
        return r;
    endfunction

    always @(negedge clock) begin
        if (cmp_en) begin
            check("model int_n", 32'(int_n), 32'(m_phase != P_REQ));
            check("model int_ack", 32'(int_ack), (m_phase == P_ACK) ? (32'd1 << m_sel) : 32'd0);
            check("model jump_addr", 32'(jump_addr), 32'((64 + 8 * m_sel) % 256));
            check("model Do", 32'(Do), 32'(e_do()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        cs = 1'b1; A = a; Di = d; wr_n = 1'b0;
        tick();
        wr_n = 1'b1; cs = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [7:0] exp);
        cs = 1'b1; A = a; rd_n = 1'b0;
        #1;
        check(nm, 32'(Do), 32'(exp));
        rd_n = 1'b1; cs = 1'b0;
    endtask

    task automatic strobes(input logic lo);
        m1_n = !lo; iorq_n = !lo;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) tick();
        cmp_en = 1'b1;
        check("reset int_n", 32'(int_n), 32'd1);
        check("reset int_ack", 32'(int_ack), 32'd0);
        check("reset jump_addr", 32'(jump_addr), 32'h40);
        check("reset jump8", 32'(jump8), 32'hF0);
        rd_chk("reset IF", IFA, 8'hE0);
        reset_n = 1'b1;
        tick();

        // 1: single source, full handshake
        bus_wr(IEA, 8'h1F);
        int_req[2] = 1'b1;
        tick();
        check("t1 int_n one cycle", 32'(int_n), 32'd1);
        tick();
        check("t1 int_n low", 32'(int_n), 32'd0);
        check("t1 jump", 32'(jump_addr), 32'h50);
        int_req[2] = 1'b0;
        strobes(1'b1);
        tick();
        check("t1 int_ack", 32'(int_ack), 32'h04);
        tick();
        check("t1 ack one cycle", 32'(int_ack), 32'h00);
        strobes(1'b0);
        tick();
        rd_chk("t1 IF", IFA, 8'hE0);
        rd_chk("t1 IE", IEA, 8'hFF);

        // 2: two sources together, priority order
        int_req = 5'b10001;
        tick(); tick();
        check("t2 first jump", 32'(jump_addr), 32'h40);
        int_req = '0;
        strobes(1'b1);
        tick();
        check("t2 first ack", 32'(int_ack), 32'h01);
        tick(); strobes(1'b0); tick(); tick();
        check("t2 second jump", 32'(jump_addr), 32'h60);
        strobes(1'b1);
        tick();
        check("t2 second ack", 32'(int_ack), 32'h10);
        tick(); strobes(1'b0); tick();
        rd_chk("t2 IF", IFA, 8'hE0);

        // 3: masked source, then enabled
        bus_wr(IEA, 8'h00);
        int_req[1] = 1'b1;
        tick(); tick();
        check("t3 masked int_n", 32'(int_n), 32'd1);
        rd_chk("t3 IF", IFA, 8'hE2);
        int_req[1] = 1'b0;
        bus_wr(IEA, 8'h02);
        tick();
        check("t3 int_n low", 32'(int_n), 32'd0);
        check("t3 jump", 32'(jump_addr), 32'h48);
        strobes(1'b1); tick(); tick(); strobes(1'b0); tick();

        // 4: software withdraws the request
        bus_wr(IEA, 8'h1F);
        int_req[3] = 1'b1;
        tick(); tick();
        check("t4 int_n low", 32'(int_n), 32'd0);
        int_req[3] = 1'b0;
        bus_wr(IFA, 8'h00);
        tick();
        check("t4 withdrawn int_n", 32'(int_n), 32'd1);
        check("t4 no ack", 32'(int_ack), 32'd0);
        tick();
        check("t4 still idle", 32'(int_n), 32'd1);

        // 5: new edge during ACK keeps IF set
        int_req[3] = 1'b1;
        tick(); tick();
        check("t5 jump", 32'(jump_addr), 32'h58);
        int_req[3] = 1'b0;
        strobes(1'b1);
        tick();
        check("t5 ack", 32'(int_ack), 32'h08);
        int_req[3] = 1'b1;
        tick();
        check("t5 ack done", 32'(int_ack), 32'h00);
        rd_chk("t5 IF kept", IFA, 8'hE8);
        strobes(1'b0); tick(); tick();
        check("t5 rerequest", 32'(int_n), 32'd0);
        strobes(1'b1);
        tick();
        check("t5 second ack", 32'(int_ack), 32'h08);
        tick();

        // 6: async reset while in DONE
        reset_n = 1'b0;
        #1;
        check("t6 int_n", 32'(int_n), 32'd1);
        check("t6 int_ack", 32'(int_ack), 32'd0);
        check("t6 jump", 32'(jump_addr), 32'h40);
        rd_chk("t6 IF", IFA, 8'hE0);
        tick();
        strobes(1'b0);
        reset_n = 1'b1;
        tick();
        rd_chk("t6 level at release", IFA, 8'hE8);
        int_req = '0;

        // random traffic
        repeat (3000) begin
            for (int i = 0; i < NI; i++)
                if ($urandom_range(0, 7) == 0) int_req[i] = ~int_req[i];
            if ($urandom_range(0, 9) < 4) strobes(1'b1);
            else {m1_n, iorq_n} = 2'($urandom_range(0, 3));
            begin
                int b, s;
                b = $urandom_range(0, 12);
                s = $urandom_range(0, 2);
                A    = (s == 0) ? IFA : (s == 1) ? IEA : 16'($urandom);
                Di   = 8'($urandom);
                cs   = (b != 12);
                wr_n = !(b < 2 || b == 6);
                rd_n = !(b >= 2 && b <= 6);
            end
            tick();
        end
        cs = 1'b0; wr_n = 1'b1; rd_n = 1'b1; strobes(1'b0); int_req = '0;
        tick();

        // 8-source instance: vector arithmetic wraps modulo 256
        cs8 = 1'b1; A8 = IEA; Di8 = 8'hFF; wr8 = 1'b0;
        tick();
        wr8 = 1'b1; cs8 = 1'b0;
        req8[3] = 1'b1;
        tick(); tick();
        check("n8 int_n", 32'(int_n8), 32'd0);
        check("n8 jump wrap", 32'(jump8), 32'h08);
        cs8 = 1'b1; A8 = IFA; rd8 = 1'b0;
        #1;
        check("n8 IF read", 32'(do8), 32'h08);
        rd8 = 1'b1; cs8 = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
